hinf_frame_collector: RTL and testbench
=======================================

// Module: hinf_frame_collector
// PURPOSE
//  Receive end of the Hinftop output stream: captures the eight signed 64-bit D_out words that make up one
//  filtered frame while D_Wr is high and packs them into a 512-bit frame. Buffers up to two complete frames
//  (ping-pong) and hands each one downstream on a valid/ready handshake. Applies backpressure to Hinftop via
//  tx_full and flags frames that are truncated or overflowed.
// PARAMETERS
//  DW        64   width of one sample word (signed two's complement)
//  NWORDS    8    words per frame
//  CNTW      16   width of the delivered-frame counter
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           asynchronous, active-high reset
//  d_wr       in   1           Hinftop D_Wr: d_out carries a valid word this cycle
//  d_out      in   DW          Hinftop D_out sample word
//  done       in   1           Hinftop Done pulse: frame finished (1 cycle)
//  tx_full    out  1           to Hinftop Tx_Full: no free buffer for the next frame
//  frm_valid  out  1           frm_data holds a complete frame
//  frm_ready  in   1           downstream accepts the frame when frm_valid && frm_ready
//  frm_data   out  NWORDS*DW   packed frame, word0 in [DW-1:0], word7 in the top DW bits
//  frm_cnt    out  CNTW        number of frames delivered, wraps modulo 2^CNTW
//  trunc_err  out  1           sticky: done seen with a partial frame in progress
//  ovf_err    out  1           sticky: d_wr seen with no buffer available
// BEHAVIOUR
//  Reset values: tx_full=0, frm_valid=0, frm_data=0, frm_cnt=0, trunc_err=0, ovf_err=0,
//   both buffers FREE, wr_ptr=rd_ptr=0, word index=0.
//  Buffers: buf[0..1]. Each buffer is in one of three states: FREE, FILL or FULL.
//   Buffer state machine: FREE -> FILL on the first accepted word.
//   FILL -> FULL on the NWORDS-th word; wr_ptr toggles on that word.
//   FULL -> FREE on the output handshake; rd_ptr toggles on the handshake.
//  Capture:
//   - Each cycle with d_wr=1 and buf[wr_ptr] not FULL stores d_out into word slot idx; idx then increments.
//   - d_wr may drop mid-frame. idx holds, and no timeout applies.
//   - Word NWORDS-1 closes the frame in the same edge and resets idx to 0.
//  Output: frm_valid = (buf[rd_ptr]==FULL). frm_data is a direct mux of buf[rd_ptr].
//   Latency: the last word is captured at edge N, and frm_valid is high from edge N onward (registered state).
//   On the handshake frm_cnt increments. It wraps from 2^CNTW-1 to 0.
//   frm_data must stay stable while frm_valid=1 and frm_ready=0.
//  tx_full: registered. It is 1 when both buffers are non-FREE and idx==0, i.e. no room for a new frame.
//   It falls the cycle after the handshake frees a buffer. Hinftop samples it only at frame boundaries.
//  Simultaneous events:
//   - Capture of the last word and a handshake on the other buffer in the same cycle are both legal,
//     and both take effect.
//   - If the handshake frees buf[wr_ptr] in the same cycle that d_wr arrives, the word is accepted.
//  Overflow: d_wr=1 while buf[wr_ptr]==FULL and no handshake frees it in that cycle.
//   The word is dropped, ovf_err is set, and idx is unchanged.
//  Truncation: done=1 while idx!=0 and no last word arrives in that cycle.
//   trunc_err is set, the partial buffer returns to FREE, and idx is set to 0.
//   done with idx==0 (or coincident with the last word) is normal and has no effect.
//  Errors are sticky until rst. No arithmetic is applied to the data: words are passed through bit-exact,
//   sign preserved.
//  Reset mid-operation (async assert): all state clears immediately. Partial and full frames are discarded.
// STRUCTURE
//  Shared package hinf_pkg:
//   - constants HINF_DW=64 and HINF_NWORDS=8
//   - typedef hinf_word_t (logic signed [63:0])
//   - typedef hinf_frame_t (hinf_word_t [7:0])
//   - enum buf_state_e {FREE, FILL, FULL}
//  One sub-module, hinf_frame_buf: a single NWORDS x DW buffer with indexed word write and a state register,
//   instantiated twice. Top level holds wr_ptr, rd_ptr, idx, the counters and the error flags.
// TESTING
//  1 Reset, then d_wr high 8 cycles with d_out=-4..3:
//    frm_valid=1 one edge after the 8th word; frm_data words = -4,-3,...,3; frm_cnt=1 after the handshake.
//  2 Same frame with d_wr low for 3 cycles after word 4:
//    frame completes at the 8th accepted word; data is identical to scenario 1.
//  3 frm_ready=0, send 2 frames:
//    tx_full=1 after frame 2 and frm_data stays on frame 1. Pulse frm_ready:
//    frame 1 is delivered, tx_full=0 the next cycle, then frame 2 is valid.
//  4 With both buffers FULL, send a 3rd frame:
//    ovf_err=1, all 8 words dropped, stored frames unchanged.
//  5 5 words then done pulse:
//    trunc_err=1, buffer FREE, and the next 8 words form a clean frame.
//  6 Assert rst mid-frame (word 3) with one FULL buffer pending:
//    frm_valid=0 and tx_full=0 immediately; the next full frame is received correctly with frm_cnt starting at 0.

Source files
------------

// File: rtl/hinf_frame_collector_pkg.sv
// Shared types for the Hinftop frame collector: word/frame types and buffer states.
package hinf_pkg;

  localparam int HINF_DW     = 64;
  localparam int HINF_NWORDS = 8;

  typedef logic signed [HINF_DW-1:0] hinf_word_t;
  typedef hinf_word_t [HINF_NWORDS-1:0] hinf_frame_t;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } buf_state_e;

endpackage

// File: rtl/hinf_frame_collector_if.sv
// Bundle of the Hinftop word stream, the downstream frame handshake and the status flags.
interface hinf_frame_collector_if
  import hinf_pkg::*;
#(
  parameter int DW     = HINF_DW,
  parameter int NWORDS = HINF_NWORDS,
  parameter int CNTW   = 16
);

  logic                   d_wr;
  logic [DW-1:0]          d_out;
  logic                   done;
  logic                   tx_full;
  logic                   frm_valid;
  logic                   frm_ready;
  logic [NWORDS*DW-1:0]   frm_data;
  logic [CNTW-1:0]        frm_cnt;
  logic                   trunc_err;
  logic                   ovf_err;

  // master is the Hinftop/downstream side, slave is the collector
  modport master (
    output d_wr, d_out, done, frm_ready,
    input  tx_full, frm_valid, frm_data, frm_cnt, trunc_err, ovf_err
  );

  modport slave (
    input  d_wr, d_out, done, frm_ready,
    output tx_full, frm_valid, frm_data, frm_cnt, trunc_err, ovf_err
  );

endinterface

// File: rtl/hinf_frame_collector_buf.sv
// One frame buffer: NWORDS x DW storage with indexed word write and a FREE/FILL/FULL state register.
module hinf_frame_buf
  import hinf_pkg::*;
#(
  parameter int DW     = HINF_DW,
  parameter int NWORDS = HINF_NWORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [$clog2(NWORDS)-1:0]  i_widx,
  input  logic [DW-1:0]              i_wdata,
  input  buf_state_e                 i_state_nxt,
  output buf_state_e                 o_state,
  output logic [NWORDS*DW-1:0]       o_data
);

  logic [NWORDS-1:0][DW-1:0] r_mem;
  buf_state_e                r_state;

  // State sequencing is decided by the collector; this block only holds it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem   <= '0;
      r_state <= FREE;
    end else begin
      r_state <= i_state_nxt;
      if (i_we) begin
        r_mem[i_widx] <= i_wdata;
      end
    end
  end

  assign o_state = r_state;
  assign o_data  = r_mem;

endmodule

// File: rtl/hinf_frame_collector.sv
// Collects eight-word Hinftop frames into a ping-pong buffer pair and delivers them on valid/ready.
module hinf_frame_collector
  import hinf_pkg::*;
#(
  parameter int DW     = HINF_DW,
  parameter int NWORDS = HINF_NWORDS,
  parameter int CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hinf_frame_collector_if.slave io_bus
);

  localparam int IDXW = $clog2(NWORDS);

  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [IDXW-1:0]      r_idx;
  logic [CNTW-1:0]      r_frm_cnt;
  logic                 r_tx_full;
  logic                 r_trunc_err;
  logic                 r_ovf_err;

  buf_state_e           w_state     [2];
  buf_state_e           w_state_nxt [2];
  logic [NWORDS*DW-1:0] w_data      [2];
  logic [1:0]           w_we;
  logic                 w_hs;
  logic                 w_wr_room;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_ovf;
  logic                 w_trunc;
  logic [IDXW-1:0]      w_idx_nxt;
  logic                 w_tx_full_nxt;

  // A handshake that frees the write buffer in the same cycle makes room for the incoming word
  assign w_hs      = (w_state[r_rd_ptr] == FULL) && io_bus.frm_ready;
  assign w_wr_room = (w_state[r_wr_ptr] != FULL) || (w_hs && (r_rd_ptr == r_wr_ptr));
  assign w_accept  = io_bus.d_wr && w_wr_room;
  assign w_last    = w_accept && (r_idx == IDXW'(NWORDS - 1));
  assign w_ovf     = io_bus.d_wr && !w_wr_room;
  assign w_trunc   = io_bus.done && (r_idx != '0) && !w_last;

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_trunc || w_last) begin
      w_idx_nxt = '0;
    end else if (w_accept) begin
      w_idx_nxt = r_idx + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = w_state[i];
      if (w_hs && (r_rd_ptr == 1'(i))) begin
        w_state_nxt[i] = FREE;
      end
      if (r_wr_ptr == 1'(i)) begin
        if (w_trunc) begin
          w_state_nxt[i] = FREE;
        end else if (w_accept) begin
          w_state_nxt[i] = w_last ? FULL : FILL;
        end
      end
    end
  end

  assign w_tx_full_nxt = (w_state_nxt[0] != FREE) && (w_state_nxt[1] != FREE) && (w_idx_nxt == '0);

  for (genvar g = 0; g < 2; g++) begin : g_buf
    assign w_we[g] = w_accept && !w_trunc && (r_wr_ptr == 1'(g));

    hinf_frame_buf #(
      .DW     (DW),
      .NWORDS (NWORDS)
    ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .i_we        (w_we[g]),
      .i_widx      (r_idx),
      .i_wdata     (io_bus.d_out),
      .i_state_nxt (w_state_nxt[g]),
      .o_state     (w_state[g]),
      .o_data      (w_data[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_idx       <= '0;
      r_frm_cnt   <= '0;
      r_tx_full   <= 1'b0;
      r_trunc_err <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      if (w_last) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_hs) begin
        r_rd_ptr  <= ~r_rd_ptr;
        r_frm_cnt <= r_frm_cnt + CNTW'(1);
      end
      r_idx     <= w_idx_nxt;
      r_tx_full <= w_tx_full_nxt;
      if (w_trunc) begin
        r_trunc_err <= 1'b1;
      end
      if (w_ovf) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  assign io_bus.tx_full   = r_tx_full;
  assign io_bus.frm_valid = (w_state[r_rd_ptr] == FULL);
  assign io_bus.frm_data  = w_data[r_rd_ptr];
  assign io_bus.frm_cnt   = r_frm_cnt;
  assign io_bus.trunc_err = r_trunc_err;
  assign io_bus.ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_hinf_frame_collector.sv
// Directed bench for hinf_frame_collector with a queue-based reference model checked every cycle.
module tb_hinf_frame_collector;
  import hinf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  hinf_frame_collector_if bus ();

  hinf_frame_collector dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: completed frames wait in a queue (at most two), one partial frame may be in progress
  hinf_frame_t mQ[$];
  hinf_frame_t mPart   = '0;
  int          mCnt    = 0;
  logic [15:0] mFrmCnt = '0;
  logic        mTrunc  = 1'b0;
  logic        mOvf    = 1'b0;
  logic        mTxFull = 1'b0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 512'(act), 512'(exp));
  endtask

  task automatic checkFrame(input string name, input int base);
    hinf_frame_t expFrame;
    for (int k = 0; k < HINF_NWORDS; k++) begin
      expFrame[k] = hinf_word_t'(base + k);
    end
    checkOutput(name, bus.frm_data, expFrame);
  endtask

  always @(posedge clk or posedge rst) begin : model
    int oldCnt;
    bit last;
    if (rst) begin
      mQ.delete();
      mCnt    = 0;
      mFrmCnt = '0;
      mTrunc  = 1'b0;
      mOvf    = 1'b0;
      mTxFull = 1'b0;
    end else begin
      oldCnt = mCnt;
      last   = 1'b0;
      if (mQ.size() > 0 && bus.frm_ready === 1'b1) begin
        void'(mQ.pop_front());
        mFrmCnt++;
      end
      if (bus.d_wr === 1'b1) begin
        if (mCnt > 0 || mQ.size() < 2) begin
          mPart[mCnt] = bus.d_out;
          mCnt++;
          if (mCnt == HINF_NWORDS) begin
            mQ.push_back(mPart);
            mCnt = 0;
            last = 1'b1;
          end
        end else begin
          mOvf = 1'b1;
        end
      end
      if (bus.done === 1'b1 && oldCnt != 0 && !last) begin
        mCnt   = 0;
        mTrunc = 1'b1;
      end
      mTxFull = (mQ.size() == 2) && (mCnt == 0);
    end
  end

  always @(negedge clk) begin
    checkBit("frm_valid", bus.frm_valid, mQ.size() > 0);
    checkBit("tx_full", bus.tx_full, mTxFull);
    checkBit("trunc_err", bus.trunc_err, mTrunc);
    checkBit("ovf_err", bus.ovf_err, mOvf);
    checkOutput("frm_cnt", 512'(bus.frm_cnt), 512'(mFrmCnt));
    if (mQ.size() > 0) begin
      checkOutput("frm_data", bus.frm_data, mQ[0]);
    end
  end

  task automatic applyStimulus(input logic wr, input logic [63:0] data, input logic dn, input logic rdy);
    @(negedge clk);
    bus.d_wr      = wr;
    bus.d_out     = data;
    bus.done      = dn;
    bus.frm_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 64'd0, 1'b0, rdy);
  endtask

  task automatic sendFrame(input int base, input int gapAt, input int gapLen, input logic [7:0] rdyMask);
    for (int k = 0; k < HINF_NWORDS; k++) begin
      if (gapAt != 0 && k == gapAt) begin
        for (int g = 0; g < gapLen; g++) idle(1'b0);
      end
      applyStimulus(1'b1, 64'(base + k), 1'b0, rdyMask[k]);
    end
  endtask

  initial begin
    bus.d_wr      = 1'b0;
    bus.d_out     = '0;
    bus.done      = 1'b0;
    bus.frm_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkBit("rst_valid", bus.frm_valid, 1'b0);
    checkBit("rst_tx_full", bus.tx_full, 1'b0);
    checkOutput("rst_data", bus.frm_data, '0);
    checkOutput("rst_cnt", 512'(bus.frm_cnt), '0);
    checkBit("rst_errs", bus.trunc_err | bus.ovf_err, 1'b0);
    rst = 1'b0;

    // Plain frame of -4..3, delivered one cycle after it is offered
    sendFrame(-4, 0, 0, 8'h00);
    idle(1'b1);
    checkBit("s1_valid", bus.frm_valid, 1'b1);
    checkFrame("s1_data", -4);
    checkOutput("s1_word0", 512'(bus.frm_data[63:0]), 512'(64'hFFFF_FFFF_FFFF_FFFC));
    checkOutput("s1_word7", 512'(bus.frm_data[511:448]), 512'(64'h3));
    idle(1'b0);
    checkOutput("s1_cnt", 512'(bus.frm_cnt), 512'(16'd1));
    checkBit("s1_valid_after", bus.frm_valid, 1'b0);

    // Same data with a three-cycle stall after the fourth word
    sendFrame(-4, 4, 3, 8'h00);
    idle(1'b1);
    checkFrame("s2_data", -4);
    idle(1'b0);
    checkOutput("s2_cnt", 512'(bus.frm_cnt), 512'(16'd2));

    // Two frames held back; tx_full rises, then one release
    sendFrame(100, 0, 0, 8'h00);
    sendFrame(200, 0, 0, 8'h00);
    idle(1'b0);
    checkBit("s3_tx_full", bus.tx_full, 1'b1);
    checkOutput("s3_hold", 512'(bus.frm_data[63:0]), 512'(64'd100));
    idle(1'b1);
    idle(1'b0);
    checkBit("s3_tx_free", bus.tx_full, 1'b0);
    checkOutput("s3_cnt", 512'(bus.frm_cnt), 512'(16'd3));
    checkFrame("s3_next", 200);

    // Both buffers full, a third frame is dropped entirely
    sendFrame(300, 0, 0, 8'h00);
    idle(1'b0);
    checkBit("s4_tx_full", bus.tx_full, 1'b1);
    sendFrame(400, 0, 0, 8'h00);
    idle(1'b0);
    checkBit("s4_ovf", bus.ovf_err, 1'b1);
    checkFrame("s4_kept", 200);
    checkOutput("s4_cnt", 512'(bus.frm_cnt), 512'(16'd3));
    // Draining while a new frame streams in: the first word lands in the buffer freed that cycle
    sendFrame(500, 0, 0, 8'hFF);
    idle(1'b1);
    checkFrame("s4_stream", 500);
    idle(1'b0);
    checkOutput("s4_cnt_end", 512'(bus.frm_cnt), 512'(16'd6));

    // Five words then done: truncated, and the next frame is clean
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 64'(600 + k), 1'b0, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    idle(1'b0);
    checkBit("s5_trunc", bus.trunc_err, 1'b1);
    checkBit("s5_valid", bus.frm_valid, 1'b0);
    sendFrame(700, 0, 0, 8'h00);
    idle(1'b0);
    checkFrame("s5_clean", 700);
    sendFrame(800, 0, 0, 8'h80);
    idle(1'b0);
    checkOutput("s5_cnt", 512'(bus.frm_cnt), 512'(16'd7));
    checkFrame("s5_overlap", 800);

    // Reset mid-frame with a full frame pending
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 64'(900 + k), 1'b0, 1'b0);
    @(negedge clk);
    bus.d_wr = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkBit("s6_valid", bus.frm_valid, 1'b0);
    checkBit("s6_tx_full", bus.tx_full, 1'b0);
    checkOutput("s6_cnt", 512'(bus.frm_cnt), '0);
    checkBit("s6_errs", bus.trunc_err | bus.ovf_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sendFrame(1000, 0, 0, 8'h00);
    idle(1'b1);
    checkFrame("s6_data", 1000);
    checkOutput("s6_cnt0", 512'(bus.frm_cnt), '0);
    idle(1'b0);
    checkOutput("s6_cnt1", 512'(bus.frm_cnt), 512'(16'd1));

    idle(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
